// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit that owns the
// HI/LO architectural registers.
//   - muldiv_op_e    : operation encoding carried on the 2-bit op port
//   - muldiv_state_e : sequencing states IDLE -> RUN -> FIX -> IDLE
//   - MULDIV_WIDTH   : default operand / HI / LO width
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    MULDIV_MULT  = 2'b00,
    MULDIV_MULTU = 2'b01,
    MULDIV_DIV   = 2'b10,
    MULDIV_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// A start pulse in IDLE latches the operand magnitudes and result signs. The
// unit then runs WIDTH shift-add (multiply) or restoring-subtract (divide)
// steps. Signs are fixed up in FIX, and HI/LO are written on the edge
// leaving FIX.
//
// Ports:
//   clock, reset     : clock and synchronous active-high reset
//   start, op        : operation request (sampled only in IDLE) and opcode
//   rs_val, rt_val   : operand A (multiplicand/dividend), operand B
//   hi_we, lo_we     : MTHI/MTLO write enables, honoured only in IDLE
//   wdata            : MTHI/MTLO write data
//   busy             : operation in flight (pipeline interlock)
//   done             : one-cycle pulse after HI/LO were updated by an op
//   hi, lo           : HI/LO architectural registers
//
// Optional feature macro: MULDIV_SINGLE_CYCLE_MUL_EN
//   When defined, MULT/MULTU compute the product combinationally in IDLE and
//   go straight to FIX. Divide stays iterative.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_e    state;
  logic [CNT_W-1:0] cnt;
  // acc is the high half of the product or the partial remainder. mq is the
  // multiplier, which shifts out as product bits enter, or the dividend,
  // which shifts out as quotient bits enter.
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] opnd;
  logic             is_div;
  logic             q_neg;
  logic             r_neg;
  logic             div_zero;

  logic             is_div_in;
  logic             is_signed_in;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  function automatic logic [WIDTH-1:0] fix_w(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_2w(input logic neg, input logic [2*WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  // Decode the incoming request and strip operand signs for signed ops.
  always_comb begin
    is_div_in    = (op == MULDIV_DIV) || (op == MULDIV_DIVU);
    is_signed_in = (op == MULDIV_MULT) || (op == MULDIV_DIV);
    a_mag        = (is_signed_in && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    b_mag        = (is_signed_in && rt_val[WIDTH-1]) ? -rt_val : rt_val;
  end

  // One iteration of each algorithm. The divide difference only needs WIDTH
  // bits because it is used only when the shifted remainder is >= the
  // divisor, and then the result is always below the divisor.
  always_comb begin
    mul_sum   = {1'b0, acc} + {1'b0, opnd & {WIDTH{mq[0]}}};
    div_shift = {acc, mq[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[WIDTH-1:0] - opnd;
  end

  // Final sign fix-up. With a zero divisor the restoring loop already leaves
  // the dividend in the remainder, so only the quotient needs forcing to
  // all ones. The most-negative / -1 case falls out naturally: the magnitude
  // quotient is 2^(WIDTH-1) and no negation is applied.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (is_div) begin
      res_lo = div_zero ? '1 : fix_w(q_neg, mq);
      res_hi = fix_w(r_neg, acc);
    end else begin
      {res_hi, res_lo} = fix_2w(q_neg, {acc, mq});
    end
  end

  // Sequencer and datapath. hi/lo change only on MTHI/MTLO in IDLE or on
  // the edge leaving FIX. A start request takes priority over a coincident
  // MTHI/MTLO, which is then dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mq       <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div   <= is_div_in;
            q_neg    <= is_signed_in && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            r_neg    <= is_signed_in && rs_val[WIDTH-1];
            div_zero <= is_div_in && (rt_val == '0);
            cnt      <= CNT_W'(WIDTH);
            busy     <= 1'b1;
            acc      <= '0;
            if (is_div_in) begin
              mq   <= a_mag;
              opnd <= b_mag;
            end else begin
              mq   <= b_mag;
              opnd <= a_mag;
            end
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
            if (is_div_in) begin
              state <= RUN;
            end else begin
              {acc, mq} <= (2*WIDTH)'(a_mag) * (2*WIDTH)'(b_mag);
              state     <= FIX;
            end
`else
            state <= RUN;
`endif
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        RUN: begin
          if (is_div) begin
            acc <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            mq  <= {mq[WIDTH-2:0], div_ge};
          end else begin
            acc <= mul_sum[WIDTH:1];
            mq  <= {mul_sum[0], mq[WIDTH-1:1]};
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Directed bench for muldiv_unit at WIDTH=32. A cycle-level reference of
// HI/LO/busy/done is derived from plain integer arithmetic. Literal results
// for the documented operations are also checked after each operation.
module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] rs_val = '0;
  logic [WIDTH-1:0] rt_val = '0;
  logic             hi_we = 1'b0;
  logic             lo_we = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference state
  int               m_remaining = 0;
  logic [WIDTH-1:0] m_hi = '0;
  logic [WIDTH-1:0] m_lo = '0;
  logic [WIDTH-1:0] m_res_hi = '0;
  logic [WIDTH-1:0] m_res_lo = '0;
  logic             m_done = 1'b0;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, from plain integer arithmetic.
  function automatic void model_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] eh, output logic [31:0] el);
    longint     sp;
    logic [63:0] up;
    int         sa, sb;
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {eh, el} = sp;
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        {eh, el} = up;
      end
      2'b10: begin
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) begin
          el = 32'hFFFF_FFFF;
          eh = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000;
          eh = 32'd0;
        end else begin
          el = sa / sb;
          eh = sa % sb;
        end
      end
      default: begin
        if (b == 32'd0) begin
          el = 32'hFFFF_FFFF;
          eh = a;
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endfunction

  // Reference update: an accepted op keeps busy for WIDTH+1 cycles, then
  // lands its result with a one-cycle done.
  always @(posedge clock) begin
    if (reset) begin
      m_remaining = 0;
      m_hi        = '0;
      m_lo        = '0;
      m_done      = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_remaining == 0) begin
        if (start) begin
          model_op(op, rs_val, rt_val, m_res_hi, m_res_lo);
          m_remaining = WIDTH + 1;
        end else begin
          if (hi_we) m_hi = wdata;
          if (lo_we) m_lo = wdata;
        end
      end else begin
        m_remaining--;
        if (m_remaining == 0) begin
          m_hi   = m_res_hi;
          m_lo   = m_res_lo;
          m_done = 1'b1;
        end
      end
    end
  end

  // Compare DUT against the reference every cycle, mid-way between edges.
  always @(negedge clock) begin
    if (chk_en) begin
      checkOutput("cyc_busy", 64'(busy), 64'(m_remaining != 0));
      checkOutput("cyc_done", 64'(done), 64'(m_done));
      checkOutput("cyc_hi", 64'(hi), 64'(m_hi));
      checkOutput("cyc_lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one op and wait (bounded) for done; also measures busy length.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int busy_cycles;
    int cycles;
    op     = o;
    rs_val = a;
    rt_val = b;
    start  = 1'b1;
    tick();
    start       = 1'b0;
    busy_cycles = 0;
    cycles      = 0;
    while (!done && cycles < 200) begin
      if (busy) busy_cycles++;
      tick();
      cycles++;
    end
    checkOutput("done_seen", 64'(done), 64'd1);
    checkOutput("busy_len", 64'(busy_cycles), 64'(WIDTH + 1));
  endtask

  initial begin
    int pulses;
    repeat (3) tick();
    reset  = 1'b0;
    chk_en = 1'b1;

    checkOutput("rst_hi", 64'(hi), 64'h0);
    checkOutput("rst_lo", 64'(lo), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_done", 64'(done), 64'h0);

    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd7);
    checkOutput("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    checkOutput("mult_lo", 64'(lo), 64'hFFFF_FFEB);

    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    checkOutput("multu_lo", 64'(lo), 64'h0000_0001);

    applyStimulus(2'b11, 32'd100, 32'd7);
    checkOutput("divu_hi", 64'(hi), 64'd2);
    checkOutput("divu_lo", 64'(lo), 64'd14);

    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    checkOutput("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);

    applyStimulus(2'b10, 32'd7, 32'hFFFF_FFFE);
    checkOutput("div_negb_hi", 64'(hi), 64'd1);
    checkOutput("div_negb_lo", 64'(lo), 64'hFFFF_FFFD);

    applyStimulus(2'b10, 32'h1234_5678, 32'd0);
    checkOutput("div0_hi", 64'(hi), 64'h1234_5678);
    checkOutput("div0_lo", 64'(lo), 64'hFFFF_FFFF);

    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("divovf_hi", 64'(hi), 64'h0);
    checkOutput("divovf_lo", 64'(lo), 64'h8000_0000);

    applyStimulus(2'b00, 32'hFFFF_FFF0, 32'hFFFF_FFF0);
    checkOutput("mult_nn_hi", 64'(hi), 64'h0);
    checkOutput("mult_nn_lo", 64'(lo), 64'h100);

    // MTLO, then MTHI+MTLO together
    wdata = 32'hAA;
    lo_we = 1'b1;
    tick();
    lo_we = 1'b0;
    checkOutput("mtlo", 64'(lo), 64'hAA);
    wdata = 32'h1234;
    hi_we = 1'b1;
    lo_we = 1'b1;
    tick();
    hi_we = 1'b0;
    lo_we = 1'b0;
    checkOutput("mtboth_hi", 64'(hi), 64'h1234);
    checkOutput("mtboth_lo", 64'(lo), 64'h1234);

    // Start and writes while busy are ignored
    op     = 2'b00;
    rs_val = 32'd2;
    rt_val = 32'd3;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    op     = 2'b11;
    rs_val = 32'd9;
    rt_val = 32'd3;
    start  = 1'b1;
    wdata  = 32'hDEAD;
    lo_we  = 1'b1;
    hi_we  = 1'b1;
    tick();
    start = 1'b0;
    lo_we = 1'b0;
    hi_we = 1'b0;
    for (int i = 0; i < 100 && !done; i++) tick();
    checkOutput("busy_ign_done", 64'(done), 64'd1);
    checkOutput("busy_ign_hi", 64'(hi), 64'h0);
    checkOutput("busy_ign_lo", 64'(lo), 64'd6);
    tick();

    // Start coinciding with MTHI/MTLO: start wins
    wdata = 32'hBEEF;
    hi_we = 1'b1;
    lo_we = 1'b1;
    applyStimulus(2'b01, 32'h0001_0000, 32'h0003_0000);
    hi_we = 1'b0;
    lo_we = 1'b0;
    checkOutput("start_wins_hi", 64'(hi), 64'd3);
    checkOutput("start_wins_lo", 64'(lo), 64'd0);
    tick();

    // Reset in the middle of an op
    op     = 2'b11;
    rs_val = 32'd9;
    rt_val = 32'd3;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst_busy", 64'(busy), 64'h0);
    checkOutput("midrst_hi", 64'(hi), 64'h0);
    checkOutput("midrst_lo", 64'(lo), 64'h0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) pulses++;
      tick();
    end
    checkOutput("midrst_no_done", 64'(pulses), 64'd0);

    applyStimulus(2'b11, 32'd9, 32'd3);
    checkOutput("after_rst_hi", 64'(hi), 64'd0);
    checkOutput("after_rst_lo", 64'(lo), 64'd3);

    repeat (3) tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
